cmd_start_scheduler: RTL
========================

Name: cmd_start_scheduler

Overview:
- Upstream neighbour of the command sequencer. Decides when a stored command is sent by driving the sequencer's external-start flag.
- Two trigger sources: a synchronised external trigger pin, or an internal periodic timer.
- Closes the handshake on the sequencer's ready line, applies a programmable dead time, and counts issued and lost triggers.
- Whole block runs in the command clock domain.

Parameters:
PERIOD_WIDTH, 16, width of periodic-timer period and counter
DEAD_WIDTH, 8, width of dead-time setting and counter
ACK_TIMEOUT, 7, cycles allowed for CMD_READY to fall after a start flag

Ports:
CMD_CLK_IN  in  1  command clock, only clock of the block
CMD_RST  in  1  synchronous active-high reset
ENABLE  in  1  level; rising edge arms and clears counters, low stops
CONF_MODE  in  1  0 = external trigger, 1 = periodic timer
CONF_PERIOD  in  PERIOD_WIDTH  timer period in cycles; 0 treated as 1
CONF_COUNT  in  16  number of starts to issue; 0 = unlimited
CONF_DEADTIME  in  DEAD_WIDTH  idle cycles after CMD_READY returns high
TRIGGER_IN  in  1  asynchronous external trigger
CMD_READY  in  1  sequencer idle (high = WAIT state)
CMD_EXT_START_FLAG  out  1  one-cycle start pulse to sequencer
BUSY  out  1  high in any state except IDLE and DONE
DONE  out  1  CONF_COUNT starts issued and completed
ACK_ERROR  out  1  sticky; CMD_READY did not fall within ACK_TIMEOUT
START_CNT  out  16  starts issued since arm
LOST_CNT  out  8  requests arriving while not ARMED; saturates at 255

Behaviour:
- Clock and reset: one clock CMD_CLK_IN. Reset CMD_RST is synchronous, active-high.
- Reset values: all outputs 0, state IDLE, timer 0.
- TRIGGER_IN path: 2-FF synchroniser, then rising-edge detect. The request pulse appears 3 cycles after the pin edge. Ignored when CONF_MODE = 1.
- Periodic timer: runs only while ENABLE = 1 and CONF_MODE = 1. Reloads at max(CONF_PERIOD,1)-1 and emits a one-cycle request on reaching 0. A period of N gives requests exactly N cycles apart.
- Config inputs are quasi-static; they are sampled only while in IDLE.
- States:
  - IDLE: ENABLE rising edge -> ARMED. On that edge clear START_CNT, LOST_CNT, ACK_ERROR, DONE and reload the timer.
  - ARMED: a request -> ISSUE. ENABLE = 0 -> IDLE.
  - ISSUE (1 cycle): CMD_EXT_START_FLAG = 1, START_CNT + 1, -> WAIT_ACK.
  - WAIT_ACK: CMD_READY = 0 -> WAIT_DONE. After ACK_TIMEOUT cycles still high -> set ACK_ERROR, -> DEAD.
  - WAIT_DONE: CMD_READY = 1 -> DEAD.
  - DEAD: count CONF_DEADTIME cycles (0 = leave next cycle). On exit:
    - START_CNT == CONF_COUNT and CONF_COUNT != 0 -> DONE.
    - ENABLE = 0 -> IDLE.
    - otherwise -> ARMED.
  - DONE: holds DONE = 1. ENABLE = 0 -> IDLE.
- Flag latency: a request seen in ARMED at cycle t gives the flag at t+1.
- LOST_CNT: increments on every request pulse not consumed in ARMED, including requests during ISSUE, WAIT_*, DEAD and DONE. Saturating.
- ENABLE falling during ISSUE, WAIT_ACK or WAIT_DONE: the sequence completes (the sequencer cannot abort), then IDLE is entered at DEAD exit.
- Request and ENABLE fall in the same ARMED cycle: go to IDLE, no flag, request counted as lost.
- START_CNT wraps at 16 bits. CMD_RST mid-sequence returns to IDLE immediately with no further flag.

Decomposition:
- Shared package: state encoding constants, default widths.
- Sub-module: trigger_edge_sync (2-FF synchroniser plus rising-edge detect) for TRIGGER_IN.

Test Plan:
- Ext mode, CONF_COUNT=3, sequencer model drops ready 2 cycles after flag and holds 20 cycles; 3 triggers 100 cycles apart -> 3 flags, each exactly 4 cycles after its pin edge; DONE=1; START_CNT=3; LOST_CNT=0.
- Periodic, CONF_PERIOD=50, deadtime 0, command 20 cycles -> flags 50 cycles apart; LOST_CNT=0 after 10 starts.
- Periodic, CONF_PERIOD=10, command 30 cycles -> LOST_CNT increments about 2-3 per start; saturates at 255 on a long run.
- CMD_READY held high -> ACK_ERROR=1, 7 cycles after the flag; block returns to ARMED.
- ENABLE dropped during WAIT_DONE -> no abort; IDLE after ready returns plus dead time; no further flags.
- CMD_RST asserted in WAIT_DONE -> next cycle all outputs 0, state IDLE.

Source files
------------

// File: rtl/cmd_start_scheduler_pkg.sv
// Shared definitions for the command start scheduler: FSM encoding, default widths
// and the busy classification used for the registered BUSY output.
package cmd_start_scheduler_pkg;

  localparam int unsigned PERIOD_WIDTH_DEF = 16;
  localparam int unsigned DEAD_WIDTH_DEF   = 8;
  localparam int unsigned ACK_TIMEOUT_DEF  = 7;
  localparam int unsigned START_CNT_WIDTH  = 16;
  localparam int unsigned LOST_CNT_WIDTH   = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_DEAD      = 3'd5,
    ST_DONE      = 3'd6
  } state_e;

  function automatic logic is_busy(input state_e s);
    return !((s == ST_IDLE) || (s == ST_DONE));
  endfunction

endpackage

// File: rtl/cmd_start_scheduler_trigger_edge_sync.sv
// Two-flop synchroniser for an asynchronous trigger pin followed by a registered
// rising-edge detector; the pulse appears three clocks after the pin edge.
module trigger_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic pulse
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;
  logic pulse_q, pulse_d;

  always_comb begin
    meta_d  = async_in;
    sync_d  = meta_q;
    prev_d  = sync_q;
    pulse_d = sync_q & ~prev_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/cmd_start_scheduler.sv
// Decides when the command sequencer starts: external trigger or periodic timer,
// ready-line handshake with timeout, programmable dead time, issued/lost counters.
module cmd_start_scheduler
  import cmd_start_scheduler_pkg::*;
#(
  parameter int unsigned PERIOD_WIDTH = PERIOD_WIDTH_DEF,
  parameter int unsigned DEAD_WIDTH   = DEAD_WIDTH_DEF,
  parameter int unsigned ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
  input  logic                    CMD_CLK_IN,
  input  logic                    CMD_RST,
  input  logic                    ENABLE,
  input  logic                    CONF_MODE,
  input  logic [PERIOD_WIDTH-1:0] CONF_PERIOD,
  input  logic [15:0]             CONF_COUNT,
  input  logic [DEAD_WIDTH-1:0]   CONF_DEADTIME,
  input  logic                    TRIGGER_IN,
  input  logic                    CMD_READY,
  output logic                    CMD_EXT_START_FLAG,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    ACK_ERROR,
  output logic [15:0]             START_CNT,
  output logic [7:0]              LOST_CNT
);

  localparam int unsigned ACK_W = $clog2(ACK_TIMEOUT + 1);

  state_e                  state_q, state_d;
  logic                    en_prev_q, en_prev_d;
  logic                    mode_q, mode_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic [15:0]             count_q, count_d;
  logic [DEAD_WIDTH-1:0]   dead_cfg_q, dead_cfg_d;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d;
  logic [DEAD_WIDTH-1:0]   dead_cnt_q, dead_cnt_d;
  logic [ACK_W-1:0]        ack_cnt_q, ack_cnt_d;
  logic                    flag_q, flag_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ack_err_q, ack_err_d;
  logic [15:0]             start_cnt_q, start_cnt_d;
  logic [7:0]              lost_cnt_q, lost_cnt_d;

  logic trig_pulse;
  logic en_rise;
  logic timer_run;
  logic req;

  trigger_edge_sync u_trig_sync (
    .clk      (CMD_CLK_IN),
    .rst      (CMD_RST),
    .async_in (TRIGGER_IN),
    .pulse    (trig_pulse)
  );

  always_comb begin
    state_d     = state_q;
    en_prev_d   = ENABLE;
    mode_d      = mode_q;
    period_d    = period_q;
    count_d     = count_q;
    dead_cfg_d  = dead_cfg_q;
    timer_d     = timer_q;
    dead_cnt_d  = dead_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    done_d      = done_q;
    ack_err_d   = ack_err_q;
    start_cnt_d = start_cnt_q;
    lost_cnt_d  = lost_cnt_q;

    en_rise   = ENABLE & ~en_prev_q;
    timer_run = ENABLE & mode_q & (state_q != ST_IDLE);
    req       = mode_q ? (timer_run && (timer_q == '0)) : trig_pulse;

    if (state_q == ST_IDLE) begin
      mode_d     = CONF_MODE;
      period_d   = CONF_PERIOD;
      count_d    = CONF_COUNT;
      dead_cfg_d = CONF_DEADTIME;
    end

    // Reload at period-1 so that a period of N spaces requests exactly N cycles apart.
    if ((state_q == ST_IDLE) && en_rise) begin
      timer_d = (CONF_PERIOD == '0) ? '0 : CONF_PERIOD - 1'b1;
    end else if (timer_run) begin
      if (timer_q == '0) timer_d = (period_q == '0) ? '0 : period_q - 1'b1;
      else               timer_d = timer_q - 1'b1;
    end

    if (req && !((state_q == ST_ARMED) && ENABLE) && (lost_cnt_q != '1)) begin
      lost_cnt_d = lost_cnt_q + 8'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (en_rise) begin
          state_d     = ST_ARMED;
          start_cnt_d = '0;
          lost_cnt_d  = '0;
          ack_err_d   = 1'b0;
          done_d      = 1'b0;
        end
      end
      ST_ARMED: begin
        if (!ENABLE) begin
          state_d = ST_IDLE;
        end else if (req) begin
          state_d     = ST_ISSUE;
          start_cnt_d = start_cnt_q + 16'd1;
        end
      end
      ST_ISSUE: begin
        state_d   = ST_WAIT_ACK;
        ack_cnt_d = ACK_W'(1);
      end
      ST_WAIT_ACK: begin
        if (!CMD_READY) begin
          state_d = ST_WAIT_DONE;
        end else if (ack_cnt_q >= ACK_W'(ACK_TIMEOUT - 1)) begin
          state_d    = ST_DEAD;
          ack_err_d  = 1'b1;
          dead_cnt_d = dead_cfg_q;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (CMD_READY) begin
          state_d    = ST_DEAD;
          dead_cnt_d = dead_cfg_q;
        end
      end
      ST_DEAD: begin
        if (dead_cnt_q == '0) begin
          if ((count_q != '0) && (start_cnt_q == count_q)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else if (!ENABLE) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          dead_cnt_d = dead_cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (!ENABLE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    flag_d = (state_d == ST_ISSUE);
    busy_d = is_busy(state_d);
  end

  always_ff @(posedge CMD_CLK_IN) begin
    if (CMD_RST) begin
      state_q     <= ST_IDLE;
      en_prev_q   <= 1'b0;
      mode_q      <= 1'b0;
      period_q    <= '0;
      count_q     <= '0;
      dead_cfg_q  <= '0;
      timer_q     <= '0;
      dead_cnt_q  <= '0;
      ack_cnt_q   <= '0;
      flag_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      start_cnt_q <= '0;
      lost_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      en_prev_q   <= en_prev_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      count_q     <= count_d;
      dead_cfg_q  <= dead_cfg_d;
      timer_q     <= timer_d;
      dead_cnt_q  <= dead_cnt_d;
      ack_cnt_q   <= ack_cnt_d;
      flag_q      <= flag_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      start_cnt_q <= start_cnt_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

  assign CMD_EXT_START_FLAG = flag_q;
  assign BUSY               = busy_q;
  assign DONE               = done_q;
  assign ACK_ERROR          = ack_err_q;
  assign START_CNT          = start_cnt_q;
  assign LOST_CNT           = lost_cnt_q;

endmodule
